// File: rtl/frame_painter.sv
// Full-screen painter: sweeps H_RES x V_RES pixels per start, sourcing colour from fill, ROM or keyed ROM.
// Optional FRAME_PAINTER_BORDER_EN adds a border_colour input that overrides the frame's edge pixels.
module frame_painter #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int COLOUR_W = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ADDR_W   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic [COLOUR_W-1:0] key_colour,
`ifdef FRAME_PAINTER_BORDER_EN
    input  logic [COLOUR_W-1:0] border_colour,
`endif
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [X_W-1:0]    XMAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    YMAX = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t              state;
    logic [1:0]          m_mode;
    logic [COLOUR_W-1:0] m_fill;
    logic [COLOUR_W-1:0] m_key;
    logic [ADDR_W-1:0]   addr;
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic [COLOUR_W-1:0] held;
    logic [COLOUR_W-1:0] px;
`ifdef FRAME_PAINTER_BORDER_EN
    logic [COLOUR_W-1:0] m_border;
`endif

    assign rom_addr = addr;

    // ROM data arrives in the plot cycle, so the colour mux sits after the registers.
    always_comb begin
        px = m_fill;
        unique case (m_mode)
            2'd1:    px = rom_data;
            2'd2:    px = (rom_data == m_key) ? m_fill : rom_data;
            default: px = m_fill;
        endcase
`ifdef FRAME_PAINTER_BORDER_EN
        if (x == '0 || x == XMAX || y == '0 || y == YMAX)
            px = m_border;
`endif
    end

    assign colour = plot ? px : held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            m_mode <= '0;
            m_fill <= '0;
            m_key  <= '0;
            addr   <= '0;
            cx     <= '0;
            cy     <= '0;
            x      <= '0;
            y      <= '0;
            held   <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef FRAME_PAINTER_BORDER_EN
            m_border <= '0;
`endif
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (plot)
                held <= px;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_mode <= mode;
                        m_fill <= fill_colour;
                        m_key  <= key_colour;
`ifdef FRAME_PAINTER_BORDER_EN
                        m_border <= border_colour;
`endif
                        addr  <= '0;
                        cx    <= '0;
                        cy    <= '0;
                        busy  <= 1'b1;
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        x    <= cx;
                        y    <= cy;
                        plot <= 1'b1;
                        if (cx == XMAX) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                        if (addr == LAST)
                            state <= DRAIN;
                        else
                            addr <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Randomised bench for frame_painter: every plotted pixel is compared with a
// model that derives x/y/colour from the pixel index and the latched command.
module tb_frame_painter;

    localparam int H = 160;
    localparam int V = 120;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  fill_colour = 3'd0;
    logic [2:0]  key_colour = 3'd0;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;
`ifdef FRAME_PAINTER_BORDER_EN
    logic [2:0]  border_colour = 3'd0;
    logic [2:0]  e_border = 3'd0;
`endif

    always #5 clk = ~clk;

    frame_painter dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .mode(mode),
        .fill_colour(fill_colour),
        .key_colour(key_colour),
`ifdef FRAME_PAINTER_BORDER_EN
        .border_colour(border_colour),
`endif
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .busy(busy),
        .done(done)
    );

    int checks = 0;
    int errors = 0;
    int mon_k = 0;
    int done_cnt = 0;
    int pat = 0;
    logic [1:0]  e_mode = 2'd0;
    logic [2:0]  e_fill = 3'd0;
    logic [2:0]  e_key = 3'd0;
    logic [2:0]  rom_mem [N];
    logic        prev_plot = 1'b0;
    logic [14:0] first_xy = 15'd0;
    logic [14:0] last_xy = 15'd0;
    logic [2:0]  col51 = 3'd0;
    logic        seen51 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] rom_val(input int k);
        logic [31:0] kk;
        kk = k;
        case (pat)
            0:       return kk[2:0];
            1:       return (k % 2 == 0) ? 3'b100 : 3'b010;
            default: return rom_mem[k];
        endcase
    endfunction

    function automatic logic [2:0] exp_col(input int px, input int py);
        logic [2:0] r;
        r = rom_val(py * H + px);
`ifdef FRAME_PAINTER_BORDER_EN
        if (px == 0 || px == H - 1 || py == 0 || py == V - 1)
            return e_border;
`endif
        case (e_mode)
            2'd1:    return r;
            2'd2:    return (r == e_key) ? e_fill : r;
            default: return e_fill;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

    // Pixel k of a sweep must sit at (k mod H, k div H).
    always @(negedge clk) begin
        if (!rst) begin
            if (plot) begin
                int ex;
                int ey;
                logic [17:0] ep;
                ex = mon_k % H;
                ey = mon_k / H;
                ep = {8'(ex), 7'(ey), exp_col(ex, ey)};
                check("pixel", {14'd0, x, y, colour}, {14'd0, ep});
                check("busy_plot", {31'd0, busy}, 32'd1);
                if (mon_k == 0) first_xy = {x, y};
                last_xy = {x, y};
                if (x == 8'd5 && y == 7'd1) begin
                    col51 = colour;
                    seen51 = 1'b1;
                end
                mon_k++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_plot", {31'd0, prev_plot}, 32'd1);
            end
            prev_plot = plot;
        end else begin
            prev_plot = 1'b0;
        end
    end

    task automatic kick(input logic [1:0] m, input logic [2:0] f,
                        input logic [2:0] k, input int p, input bit ab);
        pat = p;
        e_mode = m;
        e_fill = f;
        e_key = k;
        mon_k = 0;
        done_cnt = 0;
        seen51 = 1'b0;
`ifdef FRAME_PAINTER_BORDER_EN
        e_border = 3'($urandom);
`endif
        @(negedge clk);
        mode = m;
        fill_colour = f;
        key_colour = k;
`ifdef FRAME_PAINTER_BORDER_EN
        border_colour = e_border;
`endif
        start = 1'b1;
        abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [2:0] f,
                             input logic [2:0] k, input int p,
                             input int abort_at, input bit perturb,
                             input bit start_in_done, input bit ab_start);
        bit seen;
        kick(m, f, k, p, ab_start);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            check("abort_plot", {31'd0, plot}, 32'd0);
            check("abort_busy", {31'd0, busy}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt, 0);
            check("abort_pixels", mon_k, abort_at - 1);
            check("abort_first_xy", {17'd0, first_xy}, 32'd0);
        end else begin
            seen = 1'b0;
            for (int c = 0; c < N + 20 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (perturb && c == 100) begin
                    start = 1'b1;
                    mode = 2'($urandom);
                    fill_colour = 3'($urandom);
                    key_colour = 3'($urandom);
                end else begin
                    start = 1'b0;
                end
                if (done) seen = 1'b1;
            end
            start = 1'b0;
            check("done_seen", {31'd0, seen}, 32'd1);
            check("busy_in_done", {31'd0, busy}, 32'd0);
            if (start_in_done) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("start_in_done_ignored", {31'd0, busy}, 32'd0);
            end
            repeat (3) @(posedge clk);
            #1;
            check("pixel_count", mon_k, N);
            check("done_count", done_cnt, 1);
            check("first_xy", {17'd0, first_xy}, 32'd0);
            check("last_xy", {17'd0, last_xy}, {17'd0, 8'd159, 7'd119});
            check("idle_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) rom_mem[i] = 3'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {29'd0, plot, busy, done}, 32'd0);
        check("reset_data", {18'd0, x, y, colour}, 32'd0);
        check("reset_addr", {17'd0, rom_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort", {30'd0, busy, plot}, 32'd0);

        run_frame(2'd0, 3'b100, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_frame(2'd1, 3'd0, 3'd0, 0, 4000, 1'b0, 1'b0, 1'b1);
        check("pix51_seen", {31'd0, seen51}, 32'd1);
        check("pix51_colour", {29'd0, col51}, 32'd5);
        run_frame(2'd2, 3'b000, 3'b100, 1, 3000, 1'b0, 1'b0, 1'b0);
        run_frame(2'd3, 3'($urandom), 3'($urandom), 2, 1000,
                  1'b0, 1'b0, 1'b0);
        run_frame(2'd0, 3'($urandom), 3'd0, 0, 500, 1'b0, 1'b0, 1'b0);
        run_frame(2'd1, 3'd0, 3'd0, 2, 800, 1'b0, 1'b0, 1'b0);
        run_frame(2'd2, 3'($urandom), 3'($urandom_range(0, 7)), 2, 0,
                  1'b1, 1'b1, 1'b0);

        kick(2'd0, 3'b011, 3'd0, 0, 1'b0);
        repeat (2000) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_ctl", {29'd0, plot, busy, done}, 32'd0);
        check("rst_data", {18'd0, x, y, colour}, 32'd0);
        check("rst_addr", {17'd0, rom_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_done", done_cnt, 0);
        run_frame(2'd1, 3'd0, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
